// File: rtl/reset_sequencer.sv
// Purpose: orders board reset + PLL lock into staged active-high resets (mem -> periph -> cpu) with lock-loss and warm-reset handling.
// Latency: mem release SYNC_STAGES+LOCK_CYCLES+1 edges after reset_n rises; each later stage STAGE_GAP edges apart; lock loss seen SYNC_STAGES+1 edges after pll_locked falls.
// Backpressure: none; sw_reset_req is a level sampled only in RUN and must drop low before it can trigger again.
module reset_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_CYCLES = 16,
    parameter int STAGE_GAP   = 8,
    parameter int SW_HOLD     = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       sw_reset_req,
    output logic       mem_reset,
    output logic       periph_reset,
    output logic       cpu_reset,
    output logic       seq_done,
    output logic [1:0] reset_cause
);

    // One counter serves every timed state, so it is sized for the longest wait.
    // SW_HOLD needs one extra count: the hold lasts SW_HOLD+1 cycles before periph release.
    localparam int MAX_LG  = (LOCK_CYCLES > STAGE_GAP) ? LOCK_CYCLES : STAGE_GAP;
    localparam int CNT_MAX = (MAX_LG > SW_HOLD) ? MAX_LG : SW_HOLD;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(SW_HOLD);

    localparam logic [1:0] CAUSE_PIN  = 2'b01;
    localparam logic [1:0] CAUSE_LOCK = 2'b10;
    localparam logic [1:0] CAUSE_SW   = 2'b11;

    typedef enum logic [2:0] {
        ST_ASSERT    = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_REL_MEM   = 3'd2,
        ST_REL_PERI  = 3'd3,
        ST_REL_CPU   = 3'd4,
        ST_RUN       = 3'd5,
        ST_SW_HOLD   = 3'd6
    } state_t;

    logic [SYNC_STAGES-1:0] rst_sync_q;
    logic [SYNC_STAGES-1:0] lock_sync_q;
    logic                   rst_ok;
    logic                   lock_s;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    cause_q, cause_d;
    logic          sw_armed_q, sw_armed_d;
    logic          mem_rst_q, peri_rst_q, cpu_rst_q, done_q;

    assign rst_ok = rst_sync_q[SYNC_STAGES-1];
    assign lock_s = lock_sync_q[SYNC_STAGES-1];

    // Synchronize reset release and PLL lock into the clock domain; both clear on reset_n.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q  <= '0;
            lock_sync_q <= '0;
        end else begin
            rst_sync_q  <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
            lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    // Next-state logic: lock loss outranks stage advancement and warm-reset requests.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cause_d    = cause_q;
        sw_armed_d = sw_armed_q;
        // A request must be seen low before it can start another warm reset.
        if (!sw_reset_req) begin
            sw_armed_d = 1'b1;
        end
        if (!rst_ok) begin
            state_d = ST_ASSERT;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end
                ST_WAIT_LOCK: begin
                    if (!lock_s) begin
                        cnt_d = '0;
                    end else if (cnt_q == LOCK_LAST) begin
                        state_d = ST_REL_MEM;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_REL_MEM, ST_REL_PERI, ST_REL_CPU, ST_RUN, ST_SW_HOLD: begin
                    if (!lock_s) begin
                        state_d = ST_ASSERT;
                        cnt_d   = '0;
                        cause_d = CAUSE_LOCK;
                    end else begin
                        case (state_q)
                            ST_REL_MEM: begin
                                if (cnt_q == GAP_LAST) begin
                                    state_d = ST_REL_PERI;
                                    cnt_d   = '0;
                                end else begin
                                    cnt_d = cnt_q + CW'(1);
                                end
                            end
                            ST_REL_PERI: begin
                                if (cnt_q == GAP_LAST) begin
                                    state_d = ST_REL_CPU;
                                    cnt_d   = '0;
                                end else begin
                                    cnt_d = cnt_q + CW'(1);
                                end
                            end
                            ST_REL_CPU: begin
                                state_d = ST_RUN;
                                cnt_d   = '0;
                            end
                            ST_RUN: begin
                                if (sw_reset_req && sw_armed_q) begin
                                    state_d    = ST_SW_HOLD;
                                    cnt_d      = '0;
                                    cause_d    = CAUSE_SW;
                                    sw_armed_d = 1'b0;
                                end
                            end
                            default: begin
                                if (cnt_q == HOLD_LAST) begin
                                    state_d = ST_REL_PERI;
                                    cnt_d   = '0;
                                end else begin
                                    cnt_d = cnt_q + CW'(1);
                                end
                            end
                        endcase
                    end
                end
                default: begin
                    state_d = ST_ASSERT;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, counter, cause and outputs; outputs are decoded from the next state so they
    // move on the same edge as the state, and reset_n sets every reset asynchronously.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_ASSERT;
            cnt_q      <= '0;
            cause_q    <= CAUSE_PIN;
            sw_armed_q <= 1'b1;
            mem_rst_q  <= 1'b1;
            peri_rst_q <= 1'b1;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cause_q    <= cause_d;
            sw_armed_q <= sw_armed_d;
            mem_rst_q  <= (state_d == ST_ASSERT) || (state_d == ST_WAIT_LOCK);
            peri_rst_q <= (state_d == ST_ASSERT) || (state_d == ST_WAIT_LOCK) ||
                          (state_d == ST_REL_MEM) || (state_d == ST_SW_HOLD);
            cpu_rst_q  <= (state_d != ST_REL_CPU) && (state_d != ST_RUN);
            done_q     <= (state_d == ST_RUN);
        end
    end

    assign mem_reset    = mem_rst_q;
    assign periph_reset = peri_rst_q;
    assign cpu_reset    = cpu_rst_q;
    assign seq_done     = done_q;
    assign reset_cause  = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Purpose: directed table-driven checks of reset ordering, lock filtering, lock loss and warm reset.
// Latency: each record names the edge (counted from reset_n release) after which outputs are compared.
// Backpressure: not applicable; inputs are driven between edges from one initial block.
module tb_reset_sequencer;

    logic       clock;
    logic       reset_n;
    logic       pll_locked;
    logic       sw_reset_req;
    logic       mem_reset;
    logic       periph_reset;
    logic       cpu_reset;
    logic       seq_done;
    logic [1:0] reset_cause;

    reset_sequencer #(
        .SYNC_STAGES(2),
        .LOCK_CYCLES(16),
        .STAGE_GAP  (8),
        .SW_HOLD    (16)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .pll_locked  (pll_locked),
        .sw_reset_req(sw_reset_req),
        .mem_reset   (mem_reset),
        .periph_reset(periph_reset),
        .cpu_reset   (cpu_reset),
        .seq_done    (seq_done),
        .reset_cause (reset_cause)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Expected word packs {mem, periph, cpu, seq_done, cause[1:0]}.
    typedef struct {
        int         edge_no;
        logic       pll;
        logic       sw;
        logic [5:0] exp;
    } vec_t;

    vec_t vt[$];
    int   nvec = 0;
    int   nerr = 0;
    int   ec   = 0;
    int   base = 0;
    int   a_lo, a_hi, s_lo, s_hi, b_lo, b_hi, c_lo, c_hi, d_lo, d_hi;

    task automatic add(input int e, input logic p, input logic s, input logic [5:0] x);
        vec_t v;
        v.edge_no = e;
        v.pll     = p;
        v.sw      = s;
        v.exp     = x;
        vt.push_back(v);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        ec++;
    endtask

    task automatic check(input string tag, input logic [5:0] exp);
        logic [5:0] got;
        got = {mem_reset, periph_reset, cpu_reset, seq_done, reset_cause};
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s edge %0d: mem/per/cpu/done/cause got %b required %b",
                     tag, ec - base, got, exp);
        end
    endtask

    // Hold reset_n low across two edges, confirm all resets held, release between edges.
    task automatic start_seg(input logic p, input logic s, input string tag);
        reset_n      = 1'b0;
        pll_locked   = p;
        sw_reset_req = s;
        tick();
        tick();
        check({tag, "_in_reset"}, 6'b111_0_01);
        reset_n = 1'b1;
        base    = ec;
    endtask

    task automatic run(input int lo, input int hi, input string tag);
        for (int i = lo; i <= hi; i++) begin
            pll_locked   = vt[i].pll;
            sw_reset_req = vt[i].sw;
            while ((ec - base) < vt[i].edge_no) tick();
            check($sformatf("%s_v%0d", tag, i), vt[i].exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n      = 1'b0;
        pll_locked   = 1'b0;
        sw_reset_req = 1'b0;

        // Power-on with lock present throughout.
        a_lo = vt.size();
        add( 1, 1, 0, 6'b111_0_01);
        add(18, 1, 0, 6'b111_0_01);
        add(19, 1, 0, 6'b011_0_01);
        add(26, 1, 0, 6'b011_0_01);
        add(27, 1, 0, 6'b001_0_01);
        add(34, 1, 0, 6'b001_0_01);
        add(35, 1, 0, 6'b000_0_01);
        add(36, 1, 0, 6'b000_1_01);
        a_hi = vt.size() - 1;
        // Warm reset: one-cycle request sampled at k = 41.
        s_lo = vt.size();
        add(40, 1, 0, 6'b000_1_01);
        add(41, 1, 1, 6'b011_0_11);
        add(57, 1, 0, 6'b011_0_11);
        add(58, 1, 0, 6'b001_0_11);
        add(65, 1, 0, 6'b001_0_11);
        add(66, 1, 0, 6'b000_0_11);
        add(67, 1, 0, 6'b000_1_11);
        s_hi = vt.size() - 1;
        // Lock arrives late, locks 8 cycles, drops 3, then holds: mem release at 22+17.
        b_lo = vt.size();
        add(10, 0, 0, 6'b111_0_01);
        add(18, 1, 0, 6'b111_0_01);
        add(21, 0, 0, 6'b111_0_01);
        add(38, 1, 0, 6'b111_0_01);
        add(39, 1, 0, 6'b011_0_01);
        add(47, 1, 0, 6'b001_0_01);
        add(55, 1, 0, 6'b000_0_01);
        add(56, 1, 0, 6'b000_1_01);
        b_hi = vt.size() - 1;
        // Lock drop after edge 29 (REL_PERI) and after edge 75 (RUN).
        c_lo = vt.size();
        add(29, 1, 0, 6'b001_0_01);
        add(31, 0, 0, 6'b001_0_01);
        add(32, 0, 0, 6'b111_0_10);
        add(34, 0, 0, 6'b111_0_10);
        add(51, 1, 0, 6'b111_0_10);
        add(52, 1, 0, 6'b011_0_10);
        add(60, 1, 0, 6'b001_0_10);
        add(68, 1, 0, 6'b000_0_10);
        add(69, 1, 0, 6'b000_1_10);
        add(75, 1, 0, 6'b000_1_10);
        add(77, 0, 0, 6'b000_1_10);
        add(78, 0, 0, 6'b111_0_10);
        add(80, 0, 0, 6'b111_0_10);
        add(97, 1, 0, 6'b111_0_10);
        add(98, 1, 0, 6'b011_0_10);
        add(115, 1, 0, 6'b000_1_10);
        c_hi = vt.size() - 1;
        // Request held from reset: no effect until RUN, then exactly one warm reset at k = 37.
        d_lo = vt.size();
        add(19, 1, 1, 6'b011_0_01);
        add(35, 1, 1, 6'b000_0_01);
        add(36, 1, 1, 6'b000_1_01);
        add(37, 1, 1, 6'b011_0_11);
        add(53, 1, 1, 6'b011_0_11);
        add(54, 1, 1, 6'b001_0_11);
        add(62, 1, 1, 6'b000_0_11);
        add(63, 1, 1, 6'b000_1_11);
        add(70, 1, 1, 6'b000_1_11);
        add(72, 1, 0, 6'b000_1_11);
        d_hi = vt.size() - 1;

        start_seg(1'b1, 1'b0, "poweron");
        run(a_lo, s_hi, "poweron_sw");

        start_seg(1'b0, 1'b0, "lockflt");
        run(b_lo, b_hi, "lockflt");

        start_seg(1'b1, 1'b0, "lockloss");
        run(c_lo, c_hi, "lockloss");

        start_seg(1'b1, 1'b1, "swheld");
        run(d_lo, d_hi, "swheld");

        // Pin reset between edges while in SW_HOLD, then the full power-on timing again.
        start_seg(1'b1, 1'b0, "abort");
        run(a_lo, a_hi, "abort_pre");
        run(s_lo, s_lo + 1, "abort_sw");
        sw_reset_req = 1'b0;
        repeat (4) tick();
        check("abort_in_hold", 6'b011_0_11);
        reset_n = 1'b0;
        #2;
        check("abort_async", 6'b111_0_01);
        start_seg(1'b1, 1'b0, "abort_rel");
        run(a_lo, a_hi, "abort_post");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
